alu_share_arb: RTL

ALU_SHARE_ARB -- requirements
Module: alu_share_arb

---
 rtl/alu_share_arb.sv | 139 +++++++++++++
 1 files changed

// File: rtl/alu_share_arb.sv
// alu_share_arb: two requesters time-share one 32-bit ALU behind a single
// one-entry response register, with round-robin arbitration on contention.
//
// Ports
//   clk                      clock, all state on rising edge
//   reset                    synchronous active-low reset
//   req{0,1}_valid           requester presents an operation
//   req{0,1}_ready           operation accepted this cycle (combinational)
//   req{0,1}_a, req{0,1}_b   32-bit operands
//   req{0,1}_op              3-bit ALU op code
//   resp_valid               response register holds a result
//   resp_ready               consumer takes the response this cycle
//   resp_result              registered ALU result
//   resp_id                  requester that issued the response
//   resp_err                 response came from an illegal op code
//   cnt0, cnt1               accepted-operation count per requester (wraps)
module alu_share_arb #(
  parameter int unsigned PRIO_INIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req0_op,
  input  logic [2:0]  req1_op,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_result,
  output logic        resp_id,
  output logic        resp_err,
  output logic [15:0] cnt0,
  output logic [15:0] cnt1
);

  localparam int unsigned DW = 32;
  localparam int unsigned OW = 3;
  localparam int unsigned CW = 16;

  localparam logic [OW-1:0] OP_AND = 3'b000;
  localparam logic [OW-1:0] OP_OR  = 3'b001;
  localparam logic [OW-1:0] OP_ADD = 3'b010;
  localparam logic [OW-1:0] OP_SUB = 3'b110;
  localparam logic [OW-1:0] OP_SLT = 3'b111;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic            last_q;          // requester granted on the most recent accept
  logic            slot_free_c;
  logic            gnt0_c, gnt1_c, accept_c;
  logic [DW-1:0]   sel_a_c, sel_b_c, diff_c, alu_res_c;
  logic [OW-1:0]   sel_op_c;
  logic            alu_err_c;

  // Arbitration: slot must be free; on contention the non-last requester wins.
  always_comb begin
    slot_free_c = (state_q == EMPTY) || resp_ready;
    gnt0_c      = 1'b0;
    gnt1_c      = 1'b0;
    if (reset && slot_free_c) begin
      if (req0_valid && req1_valid) begin
        if (last_q) gnt0_c = 1'b1;
        else        gnt1_c = 1'b1;
      end else if (req0_valid) begin
        gnt0_c = 1'b1;
      end else if (req1_valid) begin
        gnt1_c = 1'b1;
      end
    end
    accept_c = gnt0_c || gnt1_c;
  end

  assign req0_ready = gnt0_c;
  assign req1_ready = gnt1_c;

  // Shared ALU fed by the granted requester's operands.
  always_comb begin
    sel_a_c   = gnt1_c ? req1_a  : req0_a;
    sel_b_c   = gnt1_c ? req1_b  : req0_b;
    sel_op_c  = gnt1_c ? req1_op : req0_op;
    diff_c    = sel_a_c - sel_b_c;
    alu_res_c = '0;
    alu_err_c = 1'b0;
    case (sel_op_c)
      OP_AND:  alu_res_c = sel_a_c & sel_b_c;
      OP_OR:   alu_res_c = sel_a_c | sel_b_c;
      OP_ADD:  alu_res_c = sel_a_c + sel_b_c;
      OP_SUB:  alu_res_c = diff_c;
      OP_SLT:  alu_res_c = {(DW-1)'(0), diff_c[DW-1]};
      default: alu_err_c = 1'b1;
    endcase
  end

  // Response-slot state: FULL while the register holds an undelivered result.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept_c) state_d = FULL;
      FULL:    if (resp_ready && !accept_c) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  assign resp_valid = (state_q == FULL);

  // Response payload, round-robin pointer and per-requester counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      resp_result <= '0;
      resp_id     <= 1'b0;
      resp_err    <= 1'b0;
      last_q      <= ~1'(PRIO_INIT);
      cnt0        <= '0;
      cnt1        <= '0;
    end else if (accept_c) begin
      resp_result <= alu_res_c;
      resp_id     <= gnt1_c;
      resp_err    <= alu_err_c;
      last_q      <= gnt1_c;
      if (gnt0_c) cnt0 <= cnt0 + CW'(1);
      if (gnt1_c) cnt1 <= cnt1 + CW'(1);
    end
  end

endmodule
